d_cache_ctrl: RTL and testbench

- Memory-stage sequencer between the pipeline's load/store request and d_cache.
- Accepts one request at a time over a valid/ready handshake and drives d_cache with word-aligned word accesses only.
- Performs lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores.
- Flags misaligned accesses and cache timeouts. o_busy is the pipeline stall source.

---
 rtl/d_cache_ctrl.sv | 148 ++++++++++++++
 tb/tb_d_cache_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: load/store sequencer between the pipeline memory stage and a word-only d_cache
module d_cache_ctrl #(
  parameter int XLEN = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_write,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_unsigned,
  input  logic [XLEN-1:0] i_req_address,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_resp_valid,
  output logic [XLEN-1:0] o_resp_data,
  output logic            o_resp_error,
  output logic            o_busy,
  output logic            o_cache_req,
  output logic            o_cache_write,
  output logic [XLEN-1:0] o_cache_address,
  output logic [XLEN-1:0] o_cache_wdata,
  input  logic [XLEN-1:0] i_cache_data,
  input  logic            i_cache_done
);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, MERGE = 3'd2, WRITE = 3'd3, RESP = 3'd4;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [2:0] state_q, state_d;
  logic write_q, write_d, uns_q, uns_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic [XLEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic cache_req_q, cache_req_d, cache_write_q, cache_write_d;
  logic [XLEN-1:0] cache_address_q, cache_address_d, cache_wdata_q, cache_wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, misal, in_acc, expired;
  logic [15:0] sh;
  logic [XLEN-1:0] ld, mask, merged;
  assign o_req_ready = state_q == IDLE && !i_reset;
  assign o_busy = state_q != IDLE;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_data = resp_data_q;
  assign o_resp_error = resp_error_q;
  assign o_cache_req = cache_req_q;
  assign o_cache_write = cache_write_q;
  assign o_cache_address = cache_address_q;
  assign o_cache_wdata = cache_wdata_q;
  always_comb begin
    accept = i_req_valid && o_req_ready;
    misal = i_req_size == 2'b11 || (i_req_size == 2'b01 && i_req_address[0]) ||
            (i_req_size == 2'b10 && i_req_address[1:0] != 2'b00);
    in_acc = state_q == READ || state_q == WRITE;
    expired = TIMEOUT_CYCLES != 0 && in_acc && cnt_q == CMAX && !i_cache_done;
    sh = 16'(i_cache_data >> {off_q, 3'b000});
    ld = size_q == 2'b00 ? {{(XLEN-8){~uns_q & sh[7]}}, sh[7:0]} :
         size_q == 2'b01 ? {{(XLEN-16){~uns_q & sh[15]}}, sh} : i_cache_data;
    mask = (size_q == 2'b00 ? XLEN'(8'hFF) : XLEN'(16'hFFFF)) << {off_q, 3'b000};
    merged = (rdata_q & ~mask) | ((wdata_q << {off_q, 3'b000}) & mask);
    state_d = state_q;
    write_d = write_q;
    uns_d = uns_q;
    size_d = size_q;
    off_d = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_data_d = '0;
    cache_address_d = cache_address_q;
    cache_wdata_d = cache_wdata_q;
    cnt_d = in_acc ? cnt_q + CW'(1) : '0;
    case (state_q)
      IDLE: if (accept) begin
        write_d = i_req_write;
        uns_d = i_req_unsigned;
        size_d = i_req_size;
        off_d = i_req_address[1:0];
        wdata_d = i_req_wdata;
        cache_address_d = {i_req_address[XLEN-1:2], 2'b00};
        cache_wdata_d = i_req_wdata;
        state_d = misal ? RESP : (i_req_write && i_req_size == 2'b10) ? WRITE : READ;
        resp_valid_d = misal;
        resp_error_d = misal;
      end
      READ: if (i_cache_done) begin
        rdata_d = i_cache_data;
        state_d = write_q ? MERGE : RESP;
        resp_valid_d = !write_q;
        resp_data_d = write_q ? '0 : ld;
      end
      MERGE: begin
        cache_wdata_d = merged;
        state_d = WRITE;
      end
      WRITE: if (i_cache_done) begin
        state_d = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (expired) begin
      state_d = RESP;
      resp_valid_d = 1'b1;
      resp_error_d = 1'b1;
      resp_data_d = '0;
    end
    cache_req_d = state_d == READ || state_d == WRITE;
    cache_write_d = state_d == WRITE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= 2'b00;
      off_q <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q <= '0;
      cache_req_q <= 1'b0;
      cache_write_q <= 1'b0;
      cache_address_q <= '0;
      cache_wdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      uns_q <= uns_d;
      size_q <= size_d;
      off_q <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_data_q <= resp_data_d;
      cache_req_q <= cache_req_d;
      cache_write_q <= cache_write_d;
      cache_address_q <= cache_address_d;
      cache_wdata_q <= cache_wdata_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_d_cache_ctrl.sv
// tb_d_cache_ctrl: directed and randomized checks of d_cache_ctrl against a word-memory reference
module tb_d_cache_ctrl;
  localparam int T = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, i_req_valid, o_req_ready, i_req_write, i_req_unsigned;
  logic [1:0] i_req_size;
  logic [31:0] i_req_address, i_req_wdata, o_resp_data, o_cache_address, o_cache_wdata, i_cache_data;
  logic o_resp_valid, o_resp_error, o_busy, o_cache_req, o_cache_write, i_cache_done;
  logic [31:0] mem [256];
  int vectors = 0, miscompares = 0;
  d_cache_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_address(i_req_address), .i_req_wdata(i_req_wdata), .o_resp_valid(o_resp_valid),
    .o_resp_data(o_resp_data), .o_resp_error(o_resp_error), .o_busy(o_busy),
    .o_cache_req(o_cache_req), .o_cache_write(o_cache_write), .o_cache_address(o_cache_address),
    .o_cache_wdata(o_cache_wdata), .i_cache_data(i_cache_data), .i_cache_done(i_cache_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz, input logic u, input logic [1:0] off);
    logic [31:0] v;
    v = word >> (8 * off);
    if (sz == 2'd0) begin
      v = v % 256;
      if (!u && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!u && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction
  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] wd, input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    int n;
    r = word;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    for (int i = 0; i < n; i++) r[8 * (int'(off) + i) +: 8] = wd[8 * i +: 8];
    return r;
  endfunction
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, input int rdly, input int wdly, output logic [31:0] got);
    logic mis, rd, wr, want_err, seen;
    int idx, lr, lw, lat, want_req, nreq, cnt;
    logic [31:0] old, want_data, want_word;
    mis = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    idx = int'(a[9:2]);
    old = mem[idx];
    rd = !mis && (!w || sz != 2'd2);
    lr = rdly < T ? rdly + 1 : T;
    lw = wdly < T ? wdly + 1 : T;
    want_err = mis || (rd && rdly >= T);
    wr = !want_err && w;
    want_err = want_err || (wr && wdly >= T);
    want_req = (rd ? lr : 0) + (wr ? lw : 0);
    lat = 1 + want_req + (rd && wr ? 1 : 0);
    want_data = (w || want_err) ? 32'd0 : ref_load(old, sz, u, a[1:0]);
    want_word = ref_store(old, wd, sz, a[1:0]);
    i_req_valid = 1'b1;
    i_req_write = w;
    i_req_size = sz;
    i_req_unsigned = u;
    i_req_address = a;
    i_req_wdata = wd;
    nreq = 0;
    cnt = 0;
    seen = 1'b0;
    got = 32'd0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      i_req_write = 1'($urandom);
      i_req_size = 2'($urandom);
      i_req_address = $urandom;
      i_req_wdata = $urandom;
      i_cache_done = 1'b0;
      i_cache_data = $urandom;
      if (c == 1) chk("ready_busy", {30'd0, o_req_ready, o_busy}, 32'd1);
      if (o_resp_valid) begin
        seen = 1'b1;
        got = o_resp_data;
        chk("latency", c, lat);
        chk("resp_error", {31'd0, o_resp_error}, {31'd0, want_err});
        chk("resp_data", o_resp_data, want_data);
        chk("req_cycles", nreq, want_req);
      end
      if (o_cache_req) begin
        chk("cache_addr", o_cache_address, {a[31:2], 2'b00});
        if (cnt == (o_cache_write ? wdly : rdly)) begin
          i_cache_done = 1'b1;
          if (o_cache_write) chk("cache_wdata", o_cache_wdata, want_word);
          else i_cache_data = mem[idx];
        end
        cnt++;
        nreq++;
      end else cnt = 0;
    end
    chk("resp_seen", {31'd0, seen}, 32'd1);
    if (wr && wdly < T) mem[idx] = want_word;
    @(negedge clk);
    i_cache_done = 1'b0;
    chk("resp_pulse", {31'd0, o_resp_valid}, 32'd0);
    chk("ready_after", {31'd0, o_req_ready}, 32'd1);
  endtask
  initial begin
    logic [31:0] got;
    logic found, w;
    logic [1:0] sz;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    i_req_size = 2'd0;
    i_req_unsigned = 1'b0;
    i_req_address = 32'd0;
    i_req_wdata = 32'd0;
    i_cache_data = 32'd0;
    i_cache_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, o_req_ready}, 32'd0);
    chk("rst_flags", {26'd0, o_resp_valid, o_resp_error, o_busy, o_cache_req, o_cache_write, 1'b0}, 32'd0);
    chk("rst_resp_data", o_resp_data, 32'd0);
    chk("rst_cache_addr", o_cache_address, 32'd0);
    chk("rst_cache_wdata", o_cache_wdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, o_req_ready}, 32'd1);
    mem[8'h40] = 32'h80FF_1234;
    run_req(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 0, 0, got);
    chk("tp_load_byte", got, 32'hFFFF_FF80);
    mem[8'h80] = 32'hBEEF_0001;
    run_req(1'b0, 2'd1, 1'b1, 32'h202, 32'd0, 0, 0, got);
    chk("tp_load_half", got, 32'h0000_BEEF);
    mem[8'hC0] = 32'h1122_3344;
    run_req(1'b1, 2'd0, 1'b0, 32'h301, 32'hAA, 0, 0, got);
    run_req(1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 1, 0, got);
    chk("tp_store_byte_readback", got, 32'h1122_AA44);
    run_req(1'b0, 2'd2, 1'b0, 32'h402, 32'd0, 0, 0, got);
    run_req(1'b0, 2'd3, 1'b0, 32'h400, 32'd0, 0, 0, got);
    run_req(1'b1, 2'd1, 1'b0, 32'h403, 32'h1234, 0, 0, got);
    mem[8'h10] = 32'h0000_8001;
    run_req(1'b0, 2'd0, 1'b0, 32'h40, 32'd0, 10, 0, got);
    run_req(1'b0, 2'd1, 1'b0, 32'h40, 32'd0, 3, 0, got);
    chk("tp_timeout_edge", got, 32'hFFFF_8001);
    run_req(1'b1, 2'd2, 1'b0, 32'h44, 32'hCAFE_F00D, 0, 10, got);
    run_req(1'b1, 2'd1, 1'b0, 32'h46, 32'h5A5A, 2, 3, got);
    mem[8'h40 + 8'h00] = mem[8'h40];
    mem[8'h40] = 32'h0102_0304;
    i_req_valid = 1'b1;
    i_req_write = 1'b1;
    i_req_size = 2'd0;
    i_req_address = 32'h501;
    i_req_wdata = 32'hEE;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      i_cache_done = 1'b0;
      if (o_cache_req && o_cache_write) found = 1'b1;
      else if (o_cache_req) begin
        i_cache_done = 1'b1;
        i_cache_data = mem[8'h40];
      end
    end
    chk("rst_reach_write", {31'd0, found}, 32'd1);
    i_cache_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cache_req", {31'd0, o_cache_req}, 32'd0);
    chk("midrst_resp", {31'd0, o_resp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, o_req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", {31'd0, o_req_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_quiet", {30'd0, o_resp_valid, o_cache_req}, 32'd0);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h500, 32'd0, 0, 0, got);
    chk("midrst_no_write", got, 32'h0102_0304);
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom);
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = (sz == 2'd1) ? {a[1], 1'b0} : 2'd0;
      run_req(w, sz, 1'($urandom), a, $urandom,
              ($urandom % 5 == 0) ? 4 + int'($urandom % 3) : int'($urandom % 4),
              ($urandom % 5 == 0) ? 4 + int'($urandom % 3) : int'($urandom % 4), got);
      repeat ($urandom % 2) @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
